// File: rtl/interrupt_controller.sv
// Programmable interrupt controller: synchronizes and latches device requests, picks the
// highest-priority enabled source and hands one interrupt at a time to the CPU.
module interrupt_controller #(
  parameter int N_SRC = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [N_SRC-1:0] irq_in,
  input  logic             sel,
  input  logic [4:0]       addr,
  input  logic             wr,
  input  logic             rd,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic             intr,
  output logic [31:0]      vector,
  input  logic             ack,
  input  logic             eret
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SERV} state_t;

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_cur_id, w_cur_nxt;
  logic [N_SRC-1:0] r_s1, r_s2, r_s2_d;
  logic [N_SRC-1:0] r_pend, r_mask, r_mode;
  logic [31:0]      r_base;

  logic [N_SRC-1:0] w_set, w_clr, w_elig, w_cur_oh;
  logic [3:0]       w_win;
  logic             w_cur_elig, w_wr, w_rd;
  logic [2:0]       w_reg;
  logic             w_unused;

  assign w_wr     = sel && wr;
  assign w_rd     = sel && rd;
  assign w_reg    = addr[4:2];
  assign w_unused = ^addr[1:0];

  assign w_elig = r_pend & r_mask;
  assign w_set  = (r_mode & r_s2 & ~r_s2_d) | (~r_mode & r_s2);
  assign w_clr  = ((w_wr && w_reg == 3'd0) ? wdata[N_SRC-1:0] : '0)
                | ((r_state == S_REQ && ack) ? w_cur_oh : '0);

  // lowest index wins
  always_comb begin
    w_win = '0;
    for (int i = N_SRC-1; i >= 0; i--)
      if (w_elig[i]) w_win = 4'(i);
  end

  always_comb begin
    w_cur_oh = '0;
    for (int i = 0; i < N_SRC; i++)
      if (4'(i) == r_cur_id) w_cur_oh[i] = 1'b1;
  end
  assign w_cur_elig = |(w_cur_oh & w_elig);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_cur_id <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cur_id <= w_cur_nxt;
    end
  end

  // ack beats a software cancel; cur_id is frozen until we leave REQ/SERV
  always_comb begin
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur_id;
    case (r_state)
      S_IDLE: if (|w_elig) begin
        w_state_nxt = S_REQ;
        w_cur_nxt   = w_win;
      end
      S_REQ: begin
        if (ack) begin
          w_state_nxt = S_SERV;
        end else if (!w_cur_elig) begin
          w_state_nxt = S_IDLE;
          w_cur_nxt   = '0;
        end
      end
      S_SERV: if (eret) begin
        w_state_nxt = S_IDLE;
        w_cur_nxt   = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cur_nxt   = '0;
      end
    endcase
  end

  // a set in the same cycle as a clear wins, so no edge is ever lost
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_s2_d <= '0;
      r_pend <= '0;
      r_mask <= '0;
      r_mode <= '1;
      r_base <= 32'h0000_0008;
    end else begin
      r_s1   <= irq_in;
      r_s2   <= r_s1;
      r_s2_d <= r_s2;
      r_pend <= (r_pend & ~w_clr) | w_set;
      if (w_wr) begin
        case (w_reg)
          3'd1:    r_mask <= wdata[N_SRC-1:0];
          3'd2:    r_mode <= wdata[N_SRC-1:0];
          3'd4:    r_base <= {wdata[31:3], 3'b000};
          default: ;
        endcase
      end
    end
  end

  assign intr   = (r_state == S_REQ);
  assign vector = r_base + {25'b0, r_cur_id, 3'b000};

  always_comb begin
    rdata = '0;
    if (w_rd) begin
      case (w_reg)
        3'd0:    rdata = 32'(r_pend);
        3'd1:    rdata = 32'(r_mask);
        3'd2:    rdata = 32'(r_mode);
        3'd3:    rdata = {r_state == S_SERV, r_state == S_REQ, 26'b0, r_cur_id};
        3'd4:    rdata = r_base;
        default: rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: a behavioural model checked every cycle,
// plus hand-computed literal expectations at the key points of each scenario.
module tb_interrupt_controller;
  localparam int N = 8;

  logic          clock = 1'b0;
  logic          resetn = 1'b1;
  logic [N-1:0]  irq_in = '0;
  logic          sel = 1'b0, wr = 1'b0, rd = 1'b0, ack = 1'b0, eret = 1'b0;
  logic [4:0]    addr = '0;
  logic [31:0]   wdata = '0;
  logic [31:0]   rdata, vector;
  logic          intr;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  interrupt_controller #(.N_SRC(N)) dut (
    .clock(clock), .resetn(resetn), .irq_in(irq_in), .sel(sel), .addr(addr),
    .wr(wr), .rd(rd), .wdata(wdata), .rdata(rdata), .intr(intr),
    .vector(vector), .ack(ack), .eret(eret)
  );

  always #5 clock = ~clock;

  // model: h0..h2 are irq_in as seen 1..3 edges ago; st 0=idle 1=requesting 2=in service
  logic [N-1:0] m_h0 = '0, m_h1 = '0, m_h2 = '0;
  logic [N-1:0] m_pend = '0, m_mask = '0, m_mode = '1;
  logic [31:0]  m_base = 32'h8;
  int           m_cur = 0, m_st = 0;
  logic [N-1:0] t_set, t_clr, t_elig;
  int           t_low;

  always_comb begin
    t_set  = (m_mode & m_h1 & ~m_h2) | (~m_mode & m_h1);
    t_elig = m_pend & m_mask;
    t_clr  = '0;
    if (sel && wr && addr[4:2] == 3'd0) t_clr = wdata[N-1:0];
    if (m_st == 1 && ack) t_clr[m_cur] = 1'b1;
    t_low = 0;
    for (int i = N-1; i >= 0; i--)
      if (t_elig[i]) t_low = i;
  end

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m_h0 <= '0; m_h1 <= '0; m_h2 <= '0;
      m_pend <= '0; m_mask <= '0; m_mode <= '1; m_base <= 32'h8;
      m_cur <= 0; m_st <= 0;
    end else begin
      m_h0 <= irq_in; m_h1 <= m_h0; m_h2 <= m_h1;
      m_pend <= (m_pend & ~t_clr) | t_set;
      case (m_st)
        0: if (t_elig != 0) begin m_st <= 1; m_cur <= t_low; end
        1: if (ack) m_st <= 2;
           else if (!t_elig[m_cur]) begin m_st <= 0; m_cur <= 0; end
        default: if (eret) begin m_st <= 0; m_cur <= 0; end
      endcase
      if (sel && wr) begin
        if (addr[4:2] == 3'd1) m_mask <= wdata[N-1:0];
        if (addr[4:2] == 3'd2) m_mode <= wdata[N-1:0];
        if (addr[4:2] == 3'd4) m_base <= wdata & ~32'h7;
      end
    end
  end

  function automatic logic [31:0] exp_rdata();
    if (!(sel && rd)) return 32'h0;
    case (addr[4:2])
      3'd0: return {24'b0, m_pend};
      3'd1: return {24'b0, m_mask};
      3'd2: return {24'b0, m_mode};
      3'd3: return {m_st == 2, m_st == 1, 26'b0, 4'(m_cur)};
      3'd4: return m_base;
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (cmp_on) begin
      chk("model_intr", {31'b0, intr}, {31'b0, m_st == 1});
      chk("model_vector", vector, m_base + 32'(m_cur) * 32'd8);
      chk("model_rdata", rdata, exp_rdata());
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clock); #2; end
  endtask

  task automatic reg_wr(input logic [4:0] a, input logic [31:0] d);
    sel = 1'b1; wr = 1'b1; addr = a; wdata = d;
    step(1);
    sel = 1'b0; wr = 1'b0; wdata = '0;
  endtask

  task automatic reg_rd(input string name, input logic [4:0] a, input logic [31:0] exp);
    sel = 1'b1; rd = 1'b1; addr = a;
    #1 chk(name, rdata, exp);
    sel = 1'b0; rd = 1'b0;
  endtask

  task automatic pulse_ack();
    ack = 1'b1; step(1); ack = 1'b0;
  endtask

  task automatic pulse_eret();
    eret = 1'b1; step(1); eret = 1'b0;
  endtask

  task automatic chk_out(input string name, input logic ei, input logic [31:0] ev);
    chk({name, "_intr"}, {31'b0, intr}, {31'b0, ei});
    chk({name, "_vector"}, vector, ev);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1 resetn = 1'b0;
    #1 cmp_on = 1'b1;
    chk_out("reset", 1'b0, 32'h8);
    step(2);
    resetn = 1'b1;
    reg_rd("rst_pend", 5'h00, 32'h0);
    reg_rd("rst_mask", 5'h04, 32'h0);
    reg_rd("rst_mode", 5'h08, 32'h0000_00FF);
    reg_rd("rst_stat", 5'h0C, 32'h0);
    reg_rd("rst_base", 5'h10, 32'h8);
    reg_rd("unmapped14", 5'h14, 32'h0);
    reg_rd("unmapped1c", 5'h1C, 32'h0);
    reg_wr(5'h04, 32'hFFFF_FF03);
    reg_rd("mask_upper_ignored", 5'h07, 32'h3);

    // single edge request on id 1
    irq_in[1] = 1'b1;
    step(3);
    reg_rd("single_pend", 5'h00, 32'h2);
    chk_out("single_not_yet", 1'b0, 32'h8);
    step(1);
    chk_out("single_req", 1'b1, 32'h10);
    reg_rd("single_stat_req", 5'h0C, 32'h4000_0001);
    pulse_ack();
    chk_out("single_ack", 1'b0, 32'h10);
    reg_rd("single_pend_ack", 5'h00, 32'h0);
    reg_rd("single_stat_serv", 5'h0C, 32'h8000_0001);
    pulse_eret();
    reg_rd("single_stat_eret", 5'h0C, 32'h0);
    irq_in = '0;
    step(3);

    // priority, no preemption, hold-off during service
    reg_wr(5'h04, 32'hFF);
    irq_in[5] = 1'b1;
    step(4);
    chk_out("prio_req5", 1'b1, 32'h30);
    irq_in[2] = 1'b1;
    step(3);
    reg_rd("prio_pend", 5'h00, 32'h24);
    chk_out("prio_no_preempt", 1'b1, 32'h30);
    pulse_ack();
    reg_rd("prio_stat5", 5'h0C, 32'h8000_0005);
    pulse_eret();
    chk_out("prio_idle", 1'b0, 32'h8);
    step(1);
    chk_out("prio_req2", 1'b1, 32'h18);
    pulse_ack();
    irq_in = '0;
    step(3);
    irq_in = 8'h30;
    step(3);
    reg_rd("prio_accum", 5'h00, 32'h30);
    chk_out("prio_serv_hold", 1'b0, 32'h18);
    pulse_eret();
    step(1);
    chk_out("prio_req4", 1'b1, 32'h28);
    pulse_ack(); pulse_eret(); step(1);
    chk_out("prio_req5b", 1'b1, 32'h30);
    pulse_ack(); pulse_eret();
    irq_in = '0;
    step(3);

    // level mode
    reg_wr(5'h08, 32'h0);
    irq_in[0] = 1'b1;
    step(4);
    chk_out("lvl_req", 1'b1, 32'h8);
    pulse_ack();
    reg_rd("lvl_repend", 5'h00, 32'h1);
    reg_rd("lvl_stat", 5'h0C, 32'h8000_0000);
    pulse_eret();
    chk_out("lvl_idle", 1'b0, 32'h8);
    step(1);
    chk_out("lvl_rereq", 1'b1, 32'h8);
    pulse_ack();
    irq_in[0] = 1'b0;
    step(3);
    reg_wr(5'h00, 32'h1);
    reg_rd("lvl_cleared", 5'h00, 32'h0);
    pulse_eret();
    step(2);
    chk_out("lvl_no_rereq", 1'b0, 32'h8);

    // software cancel, then cancel racing ack
    reg_wr(5'h08, 32'hFF);
    irq_in[3] = 1'b1;
    step(4);
    chk_out("cancel_req", 1'b1, 32'h20);
    reg_wr(5'h00, 32'h08);
    step(1);
    chk_out("cancel_idle", 1'b0, 32'h8);
    reg_rd("cancel_stat", 5'h0C, 32'h0);
    irq_in[3] = 1'b0;
    step(3);
    irq_in[3] = 1'b1;
    step(4);
    chk_out("cancel2_req", 1'b1, 32'h20);
    sel = 1'b1; wr = 1'b1; addr = 5'h00; wdata = 32'h08; ack = 1'b1;
    step(1);
    sel = 1'b0; wr = 1'b0; wdata = '0; ack = 1'b0;
    reg_rd("cancel_ack_wins", 5'h0C, 32'h8000_0003);
    reg_rd("cancel_ack_pend", 5'h00, 32'h0);
    pulse_eret();
    irq_in = '0;
    step(3);

    // new edge on id 4 coinciding with its ack; BASE relocation
    irq_in[4] = 1'b1;
    step(4);
    chk_out("race_req", 1'b1, 32'h28);
    irq_in[4] = 1'b0;
    step(3);
    irq_in[4] = 1'b1;
    step(2);
    pulse_ack();
    reg_rd("race_pend_kept", 5'h00, 32'h10);
    reg_rd("race_stat", 5'h0C, 32'h8000_0004);
    reg_wr(5'h10, 32'h0000_0107);
    reg_rd("base_low_forced", 5'h10, 32'h100);
    chk_out("base_in_serv", 1'b0, 32'h120);
    pulse_eret();
    step(1);
    chk_out("race_rereq", 1'b1, 32'h120);
    pulse_ack(); pulse_eret();
    irq_in = '0;
    step(3);

    // reset in the middle of a request
    irq_in[6] = 1'b1;
    step(4);
    chk_out("mid_req", 1'b1, 32'h130);
    resetn = 1'b0;
    #1 chk_out("mid_reset", 1'b0, 32'h8);
    step(2);
    resetn = 1'b1;
    reg_rd("mid_mask", 5'h04, 32'h0);
    reg_rd("mid_mode", 5'h08, 32'hFF);
    reg_rd("mid_base", 5'h10, 32'h8);
    reg_rd("mid_pend", 5'h00, 32'h0);
    step(5);
    reg_rd("post_reset_edge", 5'h00, 32'h40);
    chk_out("post_reset_masked", 1'b0, 32'h8);
    irq_in = '0;
    step(2);

    cmp_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Programmable interrupt controller placed between peripheral interrupt lines (timer, keyboard, others) and the single-cycle CPU's interrupt input. Synchronizes and latches up to N_SRC requests, applies per-source mask and edge/level mode, picks the highest-priority pending source, and presents one request plus its handler vector to the CPU. Tracks the CPU's acknowledge and `eret` so only one interrupt is in service at a time. Software configures it through a small memory-mapped register window on the CPU data bus.

## Interface
- N_SRC, 8, number of interrupt sources (1..16); index 0 = highest priority
- clock  in  1  system clock; all state updates on rising edge
- resetn  in  1  asynchronous, active-low reset
- irq_in  in  N_SRC  raw device requests, asynchronous to clock
- sel  in  1  register window selected (address decode done outside)
- addr  in  5  byte offset within window; bits [1:0] ignored
- wr  in  1  register write strobe, qualified by sel
- rd  in  1  register read strobe, qualified by sel
- wdata  in  32  write data
- rdata  out  32  read data, combinational; 0 when !(sel&&rd) or unmapped offset
- intr  out  1  interrupt request to CPU
- vector  out  32  handler address = BASE + 8*cur_id
- ack  in  1  one-cycle pulse: CPU has taken the interrupt this edge
- eret  in  1  one-cycle pulse: CPU executed eret

## Operation
- Registers: 0x00 PEND (R; write-1-to-clear), 0x04 MASK (RW, 1 = enabled, reset 0), 0x08 MODE (RW, 1 = edge, 0 = level, reset all 1), 0x0C STAT (R: bit31 = in service, bit30 = requesting, [3:0] = cur_id), 0x10 BASE (RW, reset 0x0000_0008; bits [2:0] forced 0).
- Bits of PEND/MASK/MODE at and above N_SRC read 0, writes ignored.
- Synchronizer: 2 flops per source (s1, s2); s2_d holds previous s2 for edge detect.
- Set condition per bit: edge mode s2 & ~s2_d; level mode s2.
- Clear condition per bit: W1C write bit, or ack while in REQ for bit cur_id.
- Set and clear in same cycle: set wins (no lost edge; level source still high re-pends).
- Eligible = PEND & MASK; winner = lowest set index.
- FSM states IDLE, REQ, SERV:
- IDLE: if eligible != 0, latch cur_id = winner, go REQ.
- REQ: intr = 1. ack -> SERV (clear PEND[cur_id]). Else if PEND[cur_id]&MASK[cur_id] == 0 (software cleared/masked) -> IDLE, intr drops. ack beats cancel in same cycle. cur_id frozen in REQ; a higher-priority arrival does not preempt.
- SERV: intr = 0; eligible requests accumulate. eret -> IDLE. No nesting.
- eret in IDLE or REQ ignored; ack in IDLE or SERV ignored.
- vector = BASE + {cur_id, 3'b000}, 32-bit wrap; BASE writes take effect on vector next cycle, including during REQ.

## Timing
- Reset (async): PEND 0, MASK 0, MODE all 1, BASE 0x08, cur_id 0, state IDLE, s1/s2/s2_d 0; intr 0, vector 0x0000_0008, rdata 0.
- Latency: irq_in rising before edge k -> s1 at k, s2 at k+1, PEND at k+2, state REQ and intr = 1 after edge k+3 (enabled, IDLE).
- Edge-mode pulses must be at least 1 clock wide; shorter may be missed.
- intr and vector are registered-state outputs, stable for the whole REQ period.
- ack at edge e: state SERV and intr = 0 after e; PEND[cur_id] clear after e.
- eret at edge e in SERV: IDLE after e; if eligible pending, REQ after e+1 (intr high again 1 cycle after eret).
- Register writes apply at the edge with sel&&wr; reads reflect state before that edge.
- resetn asserted mid-REQ or mid-SERV: immediate return to reset values; pending lost.

## Test plan
- Reset: pulse resetn low mid-operation -> intr 0, vector 0x08, MASK reads 0, MODE reads 0xFF, BASE reads 0x08.
- Single edge request: MASK=0x03, irq_in[1] 0->1 before edge k -> intr=1 after k+3, vector 0x10, STAT 0x4000_0001; ack -> intr 0, PEND 0, STAT 0x8000_0001; eret -> STAT 0.
- Priority and hold-off: MASK=0xFF, raise irq_in[5] then irq_in[2] while in SERV for 5 -> after eret, next REQ vector 0x18 (id 2) then 0x30 (id 5) after its eret.
- Level mode: MODE=0x00, irq_in[0] held high -> after ack+eret intr reasserts 1 cycle after eret; drop irq_in[0] before eret -> PEND[0] clears, no re-request.
- Cancel: in REQ for id 3, write PEND W1C 0x08 -> intr 0 next cycle, state IDLE; repeat with ack in same cycle -> SERV.
- Set-vs-clear race: new edge on id 4 in same cycle as ack for id 4 -> PEND[4] remains 1, re-requested after eret; BASE=0x100 -> vector 0x120.
